// File: rtl/ram_port_arbiter.sv
// Multi-master arbiter in front of a single RAM port.
// Round-robin or fixed-priority grant, one IDLE cycle between transfers.
module ram_port_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int RR_MODE    = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             m_en,
    input  logic [NUM_PORTS-1:0]             m_wr,
    input  logic [2*NUM_PORTS-1:0]           m_size,
    input  logic [ADDR_WIDTH*NUM_PORTS-1:0]  m_addr,
    input  logic [DATA_WIDTH*NUM_PORTS-1:0]  m_data_in,
    output logic [DATA_WIDTH-1:0]            m_data_out,
    output logic [NUM_PORTS-1:0]             m_wt,
    output logic                             ram_en,
    output logic                             ram_wr,
    output logic [1:0]                       ram_size,
    output logic [ADDR_WIDTH-1:0]            ram_addr,
    output logic [DATA_WIDTH-1:0]            ram_data_in,
    input  logic [DATA_WIDTH-1:0]            ram_data_out,
    input  logic                             ram_wt,
    output logic [$clog2(NUM_PORTS)-1:0]     grant
);

    localparam int GW = $clog2(NUM_PORTS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] winner;
    logic [GW-1:0] rr_next;
    logic          done;
    int            idx;
    logic          found;

    // Datapath follows the registered grant; ram_en is the only gated signal
    assign ram_en      = (state == BUSY) & m_en[grant];
    assign ram_wr      = m_wr[grant];
    assign ram_size    = m_size[grant*2 +: 2];
    assign ram_addr    = m_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
    assign ram_data_in = m_data_in[grant*DATA_WIDTH +: DATA_WIDTH];
    assign m_data_out  = ram_data_out;
    assign done        = ram_en & ~ram_wt;

    assign rr_next = (grant == GW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        m_wt = '1;
        if (done)
            m_wt[grant] = 1'b0;
    end

    // Scan from rr_ptr (or from 0) upward with wrap; first requester wins
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (RR_MODE != 0) ? int'(rr_ptr) + k : k;
            if (idx >= NUM_PORTS)
                idx = idx - NUM_PORTS;
            if (!found && m_en[idx[GW-1:0]]) begin
                found  = 1'b1;
                winner = idx[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|m_en) begin
                        grant <= winner;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!m_en[grant]) begin
                        state <= IDLE;
                    end else if (!ram_wt) begin
                        state  <= IDLE;
                        rr_ptr <= rr_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: a 4-port round-robin instance and a 4-port
// fixed-priority instance, checked with immediate assertions.
module tb_ram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 26;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    m_en, m_wr;
    logic [2*N-1:0]  m_size;
    logic [AW*N-1:0] m_addr;
    logic [DW*N-1:0] m_data_in;
    logic [DW-1:0]   m_data_out;
    logic [N-1:0]    m_wt;
    logic            ram_en, ram_wr, ram_wt;
    logic [1:0]      ram_size;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_data_in, ram_data_out;
    logic [1:0]      grant;

    logic [N-1:0]    f_en;
    logic [N-1:0]    f_wt;
    logic            f_ram_en, f_ram_wr, f_ram_wt;
    logic [1:0]      f_ram_size;
    logic [AW-1:0]   f_ram_addr;
    logic [DW-1:0]   f_ram_data_in, f_m_data_out;
    logic [1:0]      f_grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) u_rr (
        .clk(clk), .reset(reset),
        .m_en(m_en), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_data_in(m_data_in), .m_data_out(m_data_out), .m_wt(m_wt),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_size(ram_size),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .ram_wt(ram_wt), .grant(grant)
    );

    ram_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0)) u_fp (
        .clk(clk), .reset(reset),
        .m_en(f_en), .m_wr('0), .m_size('0), .m_addr('0),
        .m_data_in('0), .m_data_out(f_m_data_out), .m_wt(f_wt),
        .ram_en(f_ram_en), .ram_wr(f_ram_wr), .ram_size(f_ram_size),
        .ram_addr(f_ram_addr), .ram_data_in(f_ram_data_in),
        .ram_data_out('0), .ram_wt(f_ram_wt), .grant(f_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        m_en         = '0;
        m_wr         = '0;
        m_size       = '0;
        m_addr       = '0;
        m_data_in    = '0;
        ram_wt       = 1'b1;
        ram_data_out = '0;
        f_en         = '0;
        f_ram_wt     = 1'b0;

        #12;
        chk("rst_ram_en", ram_en, 0);
        chk("rst_wt", m_wt, 32'hF);
        chk("rst_grant", grant, 0);
        chk("rst_f_wt", f_wt, 32'hF);
        reset = 1'b0;
        cyc();

        // all four ports request continuously, zero-wait RAM
        m_en   = 4'hF;
        ram_wt = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("rr_idle_en", ram_en, 0);
            cyc();
            #1;
            chk("rr_grant", grant, i % 4);
            chk("rr_wt", m_wt, 32'hF & ~(32'h1 << (i % 4)));
            cyc();
        end
        m_en   = '0;
        ram_wt = 1'b1;
        #1;

        // port 0 read with three wait cycles
        m_size[1:0]  = 2'b10;
        m_addr[25:0] = 26'h0000100;
        m_en         = 4'b0001;
        #1;
        chk("rd_idle_en", ram_en, 0);
        cyc();
        #1;
        chk("rd_grant", grant, 0);
        chk("rd_addr", ram_addr, 32'h100);
        chk("rd_wr", ram_wr, 0);
        for (int w = 0; w < 3; w++) begin
            chk("rd_wait_en", ram_en, 1);
            chk("rd_wait_wt", m_wt, 32'hF);
            cyc();
        end
        ram_wt       = 1'b0;
        ram_data_out = 32'hDEADBEEF;
        #1;
        chk("rd_done_wt", m_wt, 32'hE);
        chk("rd_data", m_data_out, 32'hDEADBEEF);
        cyc();
        m_en   = '0;
        ram_wt = 1'b1;
        #1;
        chk("rd_after_en", ram_en, 0);
        chk("rd_after_wt", m_wt, 32'hF);

        // port 0 write, size 2'b10
        m_wr            = 4'b0001;
        m_data_in[31:0] = 32'h12345678;
        m_en            = 4'b0001;
        #1;
        cyc();
        #1;
        for (int w = 0; w < 2; w++) begin
            chk("wr_ram_wr", ram_wr, 1);
            chk("wr_size", ram_size, 2);
            chk("wr_data", ram_data_in, 32'h12345678);
            chk("wr_wait_wt", m_wt, 32'hF);
            cyc();
        end
        ram_wt = 1'b0;
        #1;
        chk("wr_data_done", ram_data_in, 32'h12345678);
        chk("wr_done_wt", m_wt, 32'hE);
        cyc();
        m_en   = '0;
        m_wr   = '0;
        ram_wt = 1'b1;
        #1;

        // port 2 granted then aborts; rr_ptr must stay at 1
        m_en = 4'b0100;
        #1;
        cyc();
        #1;
        chk("ab_grant", grant, 2);
        chk("ab_en", ram_en, 1);
        cyc();
        m_en = 4'b0000;
        #1;
        chk("ab_drop_en", ram_en, 0);
        chk("ab_drop_wt", m_wt, 32'hF);
        cyc();
        #1;
        chk("ab_idle_en", ram_en, 0);
        chk("ab_idle_wt", m_wt, 32'hF);
        m_en = 4'b1010;
        #1;
        cyc();
        #1;
        chk("ab_ptr_grant", grant, 1);
        ram_wt = 1'b0;
        #1;
        chk("ab_ptr_wt", m_wt, 32'hD);
        cyc();
        m_en   = '0;
        ram_wt = 1'b1;
        #1;

        // async reset in the middle of a port 3 write
        m_wr                = 4'b1000;
        m_addr[3*AW +: AW]  = 26'h1FFFFFC;
        m_data_in[127:96]   = 32'hCAFEF00D;
        m_en                = 4'b1000;
        #1;
        cyc();
        #1;
        chk("ar_grant", grant, 3);
        chk("ar_en", ram_en, 1);
        chk("ar_addr", ram_addr, 32'h1FFFFFC);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_rst_en", ram_en, 0);
        chk("ar_rst_wt", m_wt, 32'hF);
        chk("ar_rst_grant", grant, 0);
        #1;
        m_en  = '0;
        m_wr  = '0;
        #1;
        reset = 1'b0;
        cyc();
        m_en = 4'b1010;
        #1;
        chk("ar_idle_en", ram_en, 0);
        cyc();
        #1;
        chk("ar_ptr0_grant", grant, 1);
        ram_wt = 1'b0;
        #1;
        chk("ar_ptr0_wt", m_wt, 32'hD);
        cyc();
        m_en   = '0;
        ram_wt = 1'b1;
        #1;

        // fixed priority: port 1 starves port 2
        f_en = 4'b0110;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("fp_idle_en", f_ram_en, 0);
            cyc();
            #1;
            chk("fp_grant", f_grant, 1);
            chk("fp_wt", f_wt, 32'hD);
            cyc();
        end
        f_en = 4'b0100;
        #1;
        cyc();
        #1;
        chk("fp_p2_grant", f_grant, 2);
        chk("fp_p2_wt", f_wt, 32'hB);
        cyc();
        f_en = '0;
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of master ports (legal 2..8).
REQ-002 Parameter ADDR_WIDTH, default 26, byte address width.
REQ-003 Parameter DATA_WIDTH, default 32, data width.
REQ-004 Parameter RR_MODE, default 1, 1 = round-robin arbitration, 0 = fixed priority (port 0 highest).
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port m_en  input  NUM_PORTS  per-port request.
REQ-008 Port m_wr  input  NUM_PORTS  per-port write flag.
REQ-009 Port m_size  input  2*NUM_PORTS  per-port access size, packed, port i at [2i+1:2i].
REQ-010 Port m_addr  input  ADDR_WIDTH*NUM_PORTS  per-port address, packed.
REQ-011 Port m_data_in  input  DATA_WIDTH*NUM_PORTS  per-port write data, packed.
REQ-012 Port m_data_out  output  DATA_WIDTH  read data, broadcast to all ports.
REQ-013 Port m_wt  output  NUM_PORTS  per-port wait; 0 marks completion.
REQ-014 Port ram_en, ram_wr  output  1 each  request and write flag to RAM.
REQ-015 Port ram_size  output  2  access size to RAM.
REQ-016 Port ram_addr  output  ADDR_WIDTH  address to RAM.
REQ-017 Port ram_data_in  output  DATA_WIDTH  write data to RAM.
REQ-018 Port ram_data_out  input  DATA_WIDTH  read data from RAM.
REQ-019 Port ram_wt  input  1  RAM wait; transfer completes in the cycle ram_en=1 and ram_wt=0.
REQ-020 Port grant  output  clog2(NUM_PORTS)  registered index of the granted port.

Function
REQ-021 Bus protocol per port: master holds en, wr, size, addr, data_in stable until the cycle it sees m_wt[i]=0; that cycle completes the transfer.
REQ-022 FSM states: IDLE, BUSY.
REQ-023 IDLE: ram_en=0; if any m_en bit set, register the winner in grant and go to BUSY on the next edge (one-cycle arbitration latency); otherwise stay in IDLE.
REQ-024 Winner, RR_MODE=1: first requesting port at or after rr_ptr, scanning upward with wrap-around modulo NUM_PORTS.
REQ-025 Winner, RR_MODE=0: lowest-index requesting port; rr_ptr is ignored.
REQ-026 BUSY: ram_en=m_en[grant]; ram_wr, ram_size, ram_addr, ram_data_in forwarded combinationally from port grant.
REQ-027 BUSY with ram_en=1 and ram_wt=0: m_wt[grant]=0, go to IDLE; rr_ptr <= (grant+1) mod NUM_PORTS.
REQ-028 BUSY with m_en[grant]=0 (master abort): ram_en=0, go to IDLE, rr_ptr unchanged, no completion signalled.
REQ-029 m_wt[i]=1 in every cycle except the completion cycle of the granted port.
REQ-030 m_data_out=ram_data_out at all times; valid for reads only in the completion cycle.
REQ-031 Requests arriving while BUSY wait; they are arbitrated only in the next IDLE cycle; no preemption.
REQ-032 A port that completes and immediately re-requests is arbitrated again after one IDLE cycle; under RR_MODE=1 it loses to any other requester.
REQ-033 Maximum throughput: one transfer per (RAM latency + 1 IDLE cycle).

Reset
REQ-034 While reset=1: state=IDLE, grant=0, rr_ptr=0, ram_en=0, m_wt all ones; takes effect immediately, independent of clk.
REQ-035 Reset asserted in BUSY abandons the transfer; no m_wt bit goes low; after release the arbiter starts in IDLE.

Verification
REQ-036 NUM_PORTS=2, port 0 reads addr 0x0000100, RAM returns 0xDEADBEEF after 3 wait cycles -> ram_en rises 1 cycle after m_en[0], m_wt[0]=0 in the cycle ram_wt=0, m_data_out=0xDEADBEEF, m_wt[1]=1 throughout.
REQ-037 RR_MODE=1, NUM_PORTS=4, ports 0..3 request continuously -> grants in order 0,1,2,3,0; each completes exactly once per rotation.
REQ-038 RR_MODE=0, ports 1 and 2 request continuously -> port 1 granted every time, port 2 never granted until port 1 drops en.
REQ-039 Port 2 granted, drops m_en[2] before ram_wt=0 -> ram_en=0 next cycle, FSM returns to IDLE, rr_ptr unchanged, m_wt[2] never 0.
REQ-040 Reset pulsed asynchronously mid-BUSY with write to 0x1FFFFFC -> ram_en and all m_wt outputs reach reset values without a clock edge; after release, grant=0 and the next request is arbitrated from rr_ptr=0.
REQ-041 Port 0 write of data 0x12345678, size 2'b10 -> ram_wr=1, ram_size=2'b10, ram_data_in=0x12345678 stable throughout BUSY until completion.
